// File: rtl/read_iq.sv
// read_iq: assembles little-endian signed 16-bit I/Q byte pairs and writes them, quantized, to two FIFOs.
// Optional feature: define READ_IQ_SAMPLE_CNT_EN to add a 32-bit sample_count output.
module read_iq #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int BITS       = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  i_wr_en,
    output logic                  q_wr_en,
    input  logic                  i_full,
    input  logic                  q_full
`ifdef READ_IQ_SAMPLE_CNT_EN
    ,
    output logic [31:0]           sample_count
`endif
);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0][7:0] byte_q, byte_d;
    logic            wr;

    logic        [15:0]           i16, q16;
    logic signed [DATA_WIDTH-1:0] i_ext, q_ext;

    // State, byte counter and captured sample bytes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_READ;
            cnt_q   <= 2'd0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    // Collect four bytes, then emit the pair once both FIFOs have room
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        in_rd_en = 1'b0;
        wr       = 1'b0;
        unique case (state_q)
            S_READ: begin
                if (!in_empty && !reset) begin
                    in_rd_en      = 1'b1;
                    byte_d[cnt_q] = in_dout[7:0];
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!i_full && !q_full && !reset) begin
                    wr      = 1'b1;
                    state_d = S_READ;
                end
            end
        endcase
    end

    // Sign-extend each 16-bit sample and apply the quantization shift
    always_comb begin
        i16   = {byte_q[1], byte_q[0]};
        q16   = {byte_q[3], byte_q[2]};
        i_ext = DATA_WIDTH'($signed(i16));
        q_ext = DATA_WIDTH'($signed(q16));
        i_out = i_ext <<< BITS;
        q_out = q_ext <<< BITS;
    end

    assign i_wr_en = wr;
    assign q_wr_en = wr;

`ifdef READ_IQ_SAMPLE_CNT_EN
    logic [31:0] smp_cnt_q;

    // Count pair writes; wraps naturally at 2^32
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_cnt_q <= 32'd0;
        end else if (wr) begin
            smp_cnt_q <= smp_cnt_q + 32'd1;
        end
    end

    assign sample_count = smp_cnt_q;
`endif

endmodule

// File: tb/tb_read_iq.sv
// tb_read_iq: randomized and directed bench for read_iq.
// Reference model tracks bytes per sample and pending pairs at transaction level.
module tb_read_iq;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] i_out;
    logic [31:0] q_out;
    logic        i_wr_en;
    logic        q_wr_en;
    logic        i_full;
    logic        q_full;
`ifdef READ_IQ_SAMPLE_CNT_EN
    logic [31:0] sample_count;
`endif

    read_iq dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .i_out    (i_out),
        .q_out    (q_out),
        .i_wr_en  (i_wr_en),
        .q_wr_en  (q_wr_en),
        .i_full   (i_full),
        .q_full   (q_full)
`ifdef READ_IQ_SAMPLE_CNT_EN
        ,
        .sample_count (sample_count)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  src[$];
    logic [31:0] ei[$];
    logic [31:0] eq[$];
    int          mb   = 0;
    bit          pend = 1'b0;
    int          nwr  = 0;
    int          ncnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] quant(input logic [7:0] lo,
                                          input logic [7:0] hi);
        logic signed [15:0] s;
        s = {hi, lo};
        return 32'(int'(s) * 1024);
    endfunction

    task automatic push_sample(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [31:0] ie, input logic [31:0] qe);
        src.push_back(b0);
        src.push_back(b1);
        src.push_back(b2);
        src.push_back(b3);
        ei.push_back(ie);
        eq.push_back(qe);
    endtask

    task automatic push_rand();
        logic [7:0] b[4];
        foreach (b[k]) b[k] = 8'($urandom);
        push_sample(b[0], b[1], b[2], b[3],
                    quant(b[0], b[1]), quant(b[2], b[3]));
    endtask

    // One clock: drive at negedge, check after settle, update model at posedge
    task automatic cyc(input bit fe, input bit ifl, input bit qfl,
                       input bit rs);
        bit erd, ewr, rd_dut;
        reset    = rs;
        in_empty = fe || (src.size() == 0);
        in_dout  = (src.size() > 0) ? src[0] : 8'h00;
        i_full   = ifl;
        q_full   = qfl;
        #1;
        erd = !rs && !in_empty && !pend;
        ewr = !rs && pend && !ifl && !qfl;
        chk("in_rd_en", 32'(in_rd_en), 32'(erd));
        chk("i_wr_en", 32'(i_wr_en), 32'(ewr));
        chk("q_wr_en", 32'(q_wr_en), 32'(ewr));
        if (rs) begin
            chk("i_out_rst", i_out, 32'h0);
            chk("q_out_rst", q_out, 32'h0);
        end else if (pend && ei.size() > 0) begin
            chk("i_out", i_out, ei[0]);
            chk("q_out", q_out, eq[0]);
        end
        rd_dut = in_rd_en;
        @(posedge clock);
        if (rd_dut && src.size() > 0) void'(src.pop_front());
        if (rs) begin
            mb   = 0;
            pend = 1'b0;
            ncnt = 0;
        end else begin
            if (erd) begin
                mb++;
                if (mb == 4) begin
                    mb   = 0;
                    pend = 1'b1;
                end
            end
            if (ewr) begin
                if (ei.size() > 0) begin
                    void'(ei.pop_front());
                    void'(eq.pop_front());
                end
                pend = 1'b0;
                nwr++;
                ncnt++;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        int base;
        int budget;
        reset    = 1'b1;
        in_dout  = 8'h00;
        in_empty = 1'b1;
        i_full   = 1'b0;
        q_full   = 1'b0;
        @(negedge clock);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Directed: known bytes, immediate write
        push_sample(8'h34, 8'h12, 8'hCD, 8'hAB, 32'h0048D000, 32'hFEAF3400);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_single", 32'(nwr), 32'd1);

        // Q FIFO full for 7 cycles holds the pair
        push_sample(8'h34, 8'h12, 8'hCD, 8'hAB, 32'h0048D000, 32'hFEAF3400);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wr_held", 32'(nwr), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_after_full", 32'(nwr), 32'd2);

        // in_empty toggling between bytes of two samples
        push_rand();
        push_rand();
        for (int i = 0; i < 40; i++) cyc(i[0], 1'b0, 1'b0, 1'b0);
        chk("wr_toggle", 32'(nwr), 32'd4);
        chk("src_toggle", 32'(src.size()), 32'd0);

        // Reset after two bytes discards the partial sample
        src.push_back(8'h11);
        src.push_back(8'h22);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        push_sample(8'h01, 8'h00, 8'hFF, 8'hFF, 32'h00000400, 32'hFFFFFC00);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_post_rst", 32'(nwr), 32'd5);

        // Continuous 100-sample stream in 500 cycles
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        base = nwr;
        for (int i = 0; i < 100; i++) push_rand();
        repeat (500) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_stream", 32'(nwr - base), 32'd100);
        chk("src_stream", 32'(src.size()), 32'd0);
`ifdef READ_IQ_SAMPLE_CNT_EN
        chk("sample_count", sample_count, 32'd100);
        force dut.smp_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.smp_cnt_q;
        push_rand();
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sample_wrap", sample_count, 32'd0);
`endif

        // Randomized empty/full backpressure
        base = nwr;
        for (int i = 0; i < 60; i++) push_rand();
        budget = 0;
        while ((ei.size() > 0 || pend) && budget < 5000) begin
            cyc(($urandom % 3) == 0, ($urandom % 5) == 0,
                ($urandom % 5) == 0, 1'b0);
            budget++;
        end
        chk("drain_rand", 32'(ei.size()), 32'd0);
        chk("wr_rand", 32'(nwr - base), 32'd60);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
